// File: rtl/seg7_scan_driver_if.sv
// Bundle of the value/strobe inputs and scanned display outputs of seg7_scan_driver.
interface seg7_scan_driver_if #(
    parameter int unsigned DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic [DIGITS-1:0]   blank;
    logic [6:0]          segments;
    logic [DIGITS-1:0]   digit_en;
    logic                pending;
    logic                frame;

    modport master (
        output value, load, blank,
        input  segments, digit_en, pending, frame
    );

    modport slave (
        input  value, load, blank,
        output segments, digit_en, pending, frame
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver with frame-aligned value commit.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 1024
) (
    input  logic              clk,
    input  logic              reset,
    seg7_scan_driver_if.slave bus
);
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PCNT_W = $clog2(PRESCALE);
    localparam int unsigned VAL_W  = 4 * DIGITS;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
            4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
            4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
            4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
        endcase
        return g;
    endfunction

    logic [PCNT_W-1:0] pcnt_q,     pcnt_d;
    logic [IDX_W-1:0]  idx_q,      idx_d;
    logic [VAL_W-1:0]  shadow_q,   shadow_d;
    logic [VAL_W-1:0]  disp_q,     disp_d;
    logic              pending_q,  pending_d;
    logic              frame_q,    frame_d;
    logic [DIGITS-1:0] digit_en_q, digit_en_d;
    logic [6:0]        segments_q, segments_d;

    logic              slot_end;
    logic              wrap;
    logic [DIGITS-1:0] lzb;
    logic [3:0]        cur_nib;
    logic              cur_blank;

    // Leading-zero mask: a digit blanks when it and every more-significant nibble is zero.
    always_comb begin
        logic run;
        lzb = '0;
        run = 1'b1;
`ifdef SEG7_LZB_EN
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            run    = run & (disp_q[4*i +: 4] == 4'h0);
            lzb[i] = run;
        end
`else
        run = 1'b0;
        lzb = {DIGITS{run}};
`endif
    end

    always_comb begin
        slot_end  = (pcnt_q == PCNT_W'(PRESCALE - 1));
        wrap      = slot_end && (idx_q == IDX_W'(DIGITS - 1));

        pcnt_d    = slot_end ? '0 : pcnt_q + PCNT_W'(1);
        idx_d     = idx_q;
        if (slot_end) idx_d = wrap ? '0 : idx_q + IDX_W'(1);

        // A load on the boundary still lets the previous shadow commit first.
        shadow_d  = bus.load ? bus.value : shadow_q;
        disp_d    = (wrap && pending_q) ? shadow_q : disp_q;
        pending_d = bus.load | (pending_q & ~wrap);
        frame_d   = wrap;

        cur_nib   = 4'h0;
        cur_blank = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = disp_q[4*i +: 4];
                cur_blank = bus.blank[i] | lzb[i];
            end
        end

        // First cycle of every slot is dark to avoid ghosting between digits.
        digit_en_d = (pcnt_q == '0) ? '0 : (DIGITS'(1) << idx_q);
        segments_d = cur_blank ? 7'h00 : glyph(cur_nib);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q     <= '0;
            idx_q      <= '0;
            shadow_q   <= '0;
            disp_q     <= '0;
            pending_q  <= 1'b0;
            frame_q    <= 1'b0;
            digit_en_q <= '0;
            segments_q <= '0;
        end else begin
            pcnt_q     <= pcnt_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            disp_q     <= disp_d;
            pending_q  <= pending_d;
            frame_q    <= frame_d;
            digit_en_q <= digit_en_d;
            segments_q <= segments_d;
        end
    end

    assign bus.segments = segments_q;
    assign bus.digit_en = digit_en_q;
    assign bus.pending  = pending_q;
    assign bus.frame    = frame_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIGITS=4, PRESCALE=4 (16-cycle frame).
module tb_seg7_scan_driver;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    logic [6:0] segs [4];
    logic [3:0] ens  [4];

    seg7_scan_driver_if #(.DIGITS(4)) bus ();

    seg7_scan_driver #(.DIGITS(4), .PRESCALE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One-cycle load strobe, captured on the next rising edge.
    task automatic do_load(input logic [15:0] v);
        bus.value = v;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame && n < 40);
        chk("frame_seen", 32'(bus.frame), 32'd1);
    endtask

    // Called right after a frame pulse: samples each digit mid-slot.
    task automatic read_frame();
        for (int d = 0; d < 4; d++) begin
            repeat ((d == 0) ? 2 : 4) @(negedge clk);
            segs[d] = bus.segments;
            ens[d]  = bus.digit_en;
        end
    endtask

    task automatic check_frame(input string tag, input logic [27:0] exp);
        logic [27:0] e;
        e = exp;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("%s_seg%0d", tag, d), 32'(segs[d]), 32'(e[7*d +: 7]));
            chk($sformatf("%s_en%0d", tag, d), 32'(ens[d]), 32'(4'b0001 << d));
        end
    endtask

    task automatic load_and_show(input string tag, input logic [15:0] v, input logic [27:0] exp);
        do_load(v);
        chk({tag, "_pend_hi"}, 32'(bus.pending), 32'd1);
        wait_frame();
        chk({tag, "_pend_lo"}, 32'(bus.pending), 32'd0);
        read_frame();
        check_frame(tag, exp);
    endtask

    logic [3:0] exp_en [10];
`ifdef SEG7_LZB_EN
    localparam logic [6:0] LZ = 7'h00;
`else
    localparam logic [6:0] LZ = 7'h3F;
`endif

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        errors = 0;
        checks = 0;
        bus.value = '0;
        bus.load  = 1'b0;
        bus.blank = '0;
        exp_en = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0};

        repeat (3) @(negedge clk);
        chk("rst_en",    32'(bus.digit_en), 32'd0);
        chk("rst_seg",   32'(bus.segments), 32'd0);
        chk("rst_pend",  32'(bus.pending),  32'd0);
        chk("rst_frame", 32'(bus.frame),    32'd0);

        // Scan sequence and frame period after release.
        reset = 1'b0;
        for (int k = 0; k <= 33; k++) begin
            if (k > 0) @(negedge clk);
            if (k <= 9) chk($sformatf("scan_en_k%0d", k), 32'(bus.digit_en), 32'(exp_en[k]));
            if (k == 15 || k == 17) chk($sformatf("frame_k%0d", k), 32'(bus.frame), 32'd0);
            if (k == 16 || k == 32) chk($sformatf("frame_k%0d", k), 32'(bus.frame), 32'd1);
        end

        // Glyph sweep; expected packs digit3..digit0 glyphs.
        load_and_show("g0", 16'h3210, {7'h4F, 7'h5B, 7'h06, 7'h3F});
        load_and_show("g1", 16'h7654, {7'h07, 7'h7D, 7'h6D, 7'h66});
        load_and_show("g2", 16'hBA98, {7'h7C, 7'h77, 7'h6F, 7'h7F});
        load_and_show("g3", 16'hFEDC, {7'h71, 7'h79, 7'h5E, 7'h39});

        // Two loads in one frame: old value stays up, last load wins at the boundary.
        wait_frame();
        repeat (8) @(negedge clk);
        do_load(16'h1234);
        chk("ord_pend1", 32'(bus.pending), 32'd1);
        repeat (3) @(negedge clk);
        do_load(16'hABCD);
        chk("ord_pend2", 32'(bus.pending), 32'd1);
        @(negedge clk);
        chk("ord_old_en",  32'(bus.digit_en), 32'h8);
        chk("ord_old_seg", 32'(bus.segments), 32'h71);
        wait_frame();
        chk("ord_pend_lo", 32'(bus.pending), 32'd0);
        read_frame();
        check_frame("ord", {7'h77, 7'h7C, 7'h39, 7'h5E});

        // Load coincident with the boundary while 0x1111 is pending.
        do_load(16'h1111);
        bus.value = 16'h5555;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
        chk("coin_frame", 32'(bus.frame),   32'd1);
        chk("coin_pend",  32'(bus.pending), 32'd1);
        read_frame();
        check_frame("coin1", {7'h06, 7'h06, 7'h06, 7'h06});
        wait_frame();
        chk("coin_pend_lo", 32'(bus.pending), 32'd0);
        read_frame();
        check_frame("coin2", {7'h6D, 7'h6D, 7'h6D, 7'h6D});

        // Per-digit blank mask.
        bus.blank = 4'b0101;
        load_and_show("blk", 16'h8888, {7'h7F, 7'h00, 7'h7F, 7'h00});
        bus.blank = 4'b0000;

        // Leading zeros: blanked only when the option is built in.
        load_and_show("lzb", 16'h0040, {LZ, LZ, 7'h66, 7'h3F});

        // Mid-frame reset drops the pending value and the displayed one.
        do_load(16'h9999);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mrst_en",    32'(bus.digit_en), 32'd0);
        chk("mrst_seg",   32'(bus.segments), 32'd0);
        chk("mrst_pend",  32'(bus.pending),  32'd0);
        chk("mrst_frame", 32'(bus.frame),    32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_frame();
        chk("mrst_pend_after", 32'(bus.pending), 32'd0);
        read_frame();
        check_frame("mrst", {LZ, LZ, LZ, 7'h3F});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
